// File: rtl/musb_uart_rx.sv
// 8N1 UART receiver with 16x oversampling, majority-vote bit sampling,
// a first-word-fall-through receive FIFO and sticky framing/overrun flags.
module musb_uart_rx #(
    parameter int BUS_FREQ        = 100,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_ADDR_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       uart_rx,
    output logic [7:0]                 rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [FIFO_ADDR_WIDTH:0]   rx_count,
    output logic                       frame_error,
    output logic                       overrun,
    input  logic                       clear_errors
);

    localparam int DIVISOR = (BUS_FREQ * 1000000) / (BAUD_RATE * 16);
    localparam int TICK_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIVISOR - 1);
    localparam int DEPTH   = 1 << FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0] FULL_COUNT = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    // Two-flop synchroniser, idles high so reset never looks like a start edge
    logic [1:0] sync_reg;
    logic       rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], uart_rx};
        end
    end

    assign rx_s = sync_reg[1];

    state_t              state_reg;
    logic [TICK_W-1:0]   tick_cnt_reg;
    logic [3:0]          sample_cnt_reg;
    logic [2:0]          bit_idx_reg;
    logic [7:0]          shift_reg;
    logic                s7_reg;
    logic                s8_reg;

    logic tick;
    logic sample9;
    logic vote;

    assign tick    = (tick_cnt_reg == TICK_LAST);
    assign sample9 = tick && (sample_cnt_reg == 4'd8);
    assign vote    = (s7_reg & s8_reg) | (s7_reg & rx_s) | (s8_reg & rx_s);

    // FIFO state
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [FIFO_ADDR_WIDTH:0]   count_reg;
    logic                       full;
    logic                       pop;
    logic                       push;
    logic                       stop_eval;
    logic                       drop;
    logic                       ferr_set;

    assign full      = (count_reg == FULL_COUNT);
    assign pop       = rx_valid && rx_ready;
    assign stop_eval = (state_reg == ST_STOP) && sample9;
    // A same-cycle pop frees a slot, so a full FIFO can still accept the byte
    assign push      = stop_eval && vote && (!full || pop);
    assign drop      = stop_eval && vote && full && !pop;
    assign ferr_set  = stop_eval && !vote;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            tick_cnt_reg   <= '0;
            sample_cnt_reg <= 4'd0;
            bit_idx_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            s7_reg         <= 1'b1;
            s8_reg         <= 1'b1;
        end else begin
            if (state_reg == ST_IDLE) begin
                tick_cnt_reg   <= '0;
                sample_cnt_reg <= 4'd0;
            end else if (tick) begin
                tick_cnt_reg   <= '0;
                sample_cnt_reg <= sample_cnt_reg + 4'd1;
            end else begin
                tick_cnt_reg   <= tick_cnt_reg + 1'b1;
            end

            if (tick && (sample_cnt_reg == 4'd6)) begin
                s7_reg <= rx_s;
            end
            if (tick && (sample_cnt_reg == 4'd7)) begin
                s8_reg <= rx_s;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (sample9) begin
                        if (vote) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg   <= ST_DATA;
                            bit_idx_reg <= 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample9) begin
                        shift_reg   <= {vote, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (sample9) begin
                        state_reg <= vote ? ST_IDLE : ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage has no reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (ferr_set) begin
                frame_error <= 1'b1;
            end else if (clear_errors) begin
                frame_error <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_errors) begin
                overrun <= 1'b0;
            end
        end
    end

    assign rx_valid = (count_reg != '0);
    assign rx_count = count_reg;
    assign rx_data  = rx_valid ? mem[rd_ptr_reg] : 8'h00;

endmodule

// File: tb/tb_musb_uart_rx.sv
// Scoreboard bench for musb_uart_rx: directed frames, expected bytes queued at
// stimulus time and compared by an independent pop monitor.
module tb_musb_uart_rx;

    localparam int BUS_FREQ  = 100;
    localparam int BAUD_RATE = 1000000;
    localparam int AW        = 3;
    localparam int DIV       = (BUS_FREQ * 1000000) / (BAUD_RATE * 16);
    localparam int BIT_CLK   = 16 * DIV;
    // Edges from the start-edge drive to the stop-bit push: 3 sync/detect + 153 ticks
    localparam int PUSH_EDGE = 3 + 153 * DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uart_rx = 1'b1;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [AW:0]   rx_count;
    logic          frame_error;
    logic          overrun;
    logic          clear_errors = 1'b0;

    int pass_cnt  = 0;
    int check_cnt = 0;
    logic [7:0] exp_q [$];

    musb_uart_rx #(
        .BUS_FREQ(BUS_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .FIFO_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rx(uart_rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_count(rx_count),
        .frame_error(frame_error),
        .overrun(overrun),
        .clear_errors(clear_errors)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("ok   %s: got %0h", name, act);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pop the DUT performs is checked against the scoreboard
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                check_cnt++;
                $display("FAIL pop_extra: got %0h expected no byte", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("pop_data", {24'h0, rx_data}, {24'h0, e});
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1 uart_rx = 1'b0;
        repeat (BIT_CLK) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 uart_rx = b[i];
            repeat (BIT_CLK) @(posedge clk);
        end
        #1 uart_rx = stop_bit;
        repeat (BIT_CLK) @(posedge clk);
    endtask

    task automatic pop_one();
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(negedge clk);
        check("pop_valid", {31'h0, rx_valid}, 32'd1);
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic sample_status(input string tag, input int cnt, input logic fe, input logic ov);
        @(negedge clk);
        check({tag, "_count"}, {28'h0, rx_count}, cnt);
        check({tag, "_frame_error"}, {31'h0, frame_error}, {31'h0, fe});
        check({tag, "_overrun"}, {31'h0, overrun}, {31'h0, ov});
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear_errors = 1'b1;
        @(posedge clk);
        #1 clear_errors = 1'b0;
    endtask

    initial begin
        int lat;

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'h0, rx_valid}, 32'd0);
        check("rst_data", {24'h0, rx_data}, 32'h00);
        sample_status("rst", 0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);

        // Single frame 0xA5, latency to rx_valid
        exp_q.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!rx_valid && lat < 5 * 10 * BIT_CLK) begin
                    @(posedge clk);
                    lat++;
                    #1;
                end
            end
        join
        check("a5_latency_window", {31'h0, (lat >= PUSH_EDGE - 9) && (lat <= PUSH_EDGE + 11)}, 32'd1);
        sample_status("a5", 1, 1'b0, 1'b0);
        pop_one();
        sample_status("a5_drained", 0, 1'b0, 1'b0);

        // Nine back-to-back frames: the ninth overruns
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        repeat (BIT_CLK) @(posedge clk);
        sample_status("full9", 8, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) pop_one();
        sample_status("full9_drained", 0, 1'b0, 1'b1);
        pulse_clear();
        sample_status("ovr_cleared", 0, 1'b0, 1'b0);

        // Framing error, break, then a good frame
        send_frame(8'h3C, 1'b0);
        repeat (3 * BIT_CLK) @(posedge clk);
        sample_status("break", 0, 1'b1, 1'b0);
        #1 uart_rx = 1'b1;
        repeat (BIT_CLK) @(posedge clk);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        sample_status("after_break", 1, 1'b1, 1'b0);
        pop_one();
        pulse_clear();
        sample_status("fe_cleared", 0, 1'b0, 1'b0);

        // Glitch shorter than half a bit is a false start
        @(posedge clk);
        #1 uart_rx = 1'b0;
        repeat (BIT_CLK / 3) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (2 * BIT_CLK) @(posedge clk);
        sample_status("glitch", 0, 1'b0, 1'b0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        sample_status("after_glitch", 1, 1'b0, 1'b0);
        pop_one();

        // Full FIFO with a pop in the exact push cycle of 0x99
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            send_frame(8'h10 + 8'(i), 1'b1);
        end
        exp_q.push_back(8'h99);
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (PUSH_EDGE) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        sample_status("push_pop_full", 8, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) pop_one();
        sample_status("push_pop_drained", 0, 1'b0, 1'b0);

        // Reset mid-frame flushes the FIFO and the partial byte
        send_frame(8'h77, 1'b1);
        sample_status("pre_reset", 1, 1'b0, 1'b0);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * BIT_CLK + BIT_CLK / 2) @(posedge clk);
                #1 rst = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        repeat (BIT_CLK) @(posedge clk);
        @(negedge clk);
        check("post_reset_valid", {31'h0, rx_valid}, 32'd0);
        sample_status("post_reset", 0, 1'b0, 1'b0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        sample_status("after_reset_frame", 1, 1'b0, 1'b0);
        pop_one();

        repeat (10) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/musb_uart_rx.md
Name: musb_uart_rx

Overview:
- Synthesizable UART receiver for the SoC UART peripheral.
- Consumes the serial line driven by the simulation monitor's transmitter (or an external pin) and deserialises 8N1 frames.
- Stores received bytes in a small first-word-fall-through FIFO drained by the bus-side UART register logic.
- Reports framing errors and overruns as sticky flags.

Parameters:
- BUS_FREQ, 100, bus clock frequency in MHz
- BAUD_RATE, 115200, line rate in bit/s
- FIFO_ADDR_WIDTH, 3, log2 of FIFO depth (default depth 8)

Ports:
- clk  input  1  bus clock
- rst  input  1  synchronous active-high reset
- uart_rx  input  1  asynchronous serial line, idle high
- rx_data  output  8  byte at FIFO head; valid only while rx_valid=1
- rx_valid  output  1  FIFO not empty
- rx_ready  input  1  pop request; pop occurs when rx_valid & rx_ready
- rx_count  output  FIFO_ADDR_WIDTH+1  bytes currently held
- frame_error  output  1  sticky: stop bit sampled low
- overrun  output  1  sticky: byte dropped because FIFO was full
- clear_errors  input  1  clears frame_error and overrun

Behaviour:
- One clock; reset is synchronous and active-high. All state uses posedge clk.
- Reset values:
  - rx_valid=0, rx_count=0, rx_data=0, frame_error=0, overrun=0.
  - FSM=IDLE.
  - Synchroniser flops=1.
  - Tick counter=0.
- Synchroniser: uart_rx passes through 2 flops; all decisions use the synchronised value (2-cycle input latency).
- Oversampling:
  - DIVISOR = (BUS_FREQ*1000000)/(BAUD_RATE*16), integer truncation; default 54.
  - A tick pulses one clk every DIVISOR cycles.
  - The tick counter restarts at 0 when IDLE detects a falling edge, which phase-aligns the frame.
  - A 4-bit sample counter (0..15) advances on each tick.
- Sampling: each bit value is the majority vote of samples 7, 8 and 9.
- FSM:
  - IDLE: sync rx=0 -> START; clear sample counter and tick counter.
  - START: at sample 9 evaluate the vote. Vote=1 is a false start -> IDLE, nothing recorded. Vote=0 -> DATA with bit index 0.
  - DATA: at sample 9 of each bit, shift the vote into the shift register LSB-first. After bit index 7 -> STOP.
  - STOP: at sample 9 evaluate the vote.
    - Vote=1 and FIFO not full, or pop in the same cycle: push the byte, then go IDLE.
    - Vote=1 and FIFO full with no pop: drop the byte, set overrun, then go IDLE.
    - Vote=0: drop the byte, set frame_error, go WAIT_HIGH.
  - WAIT_HIGH: stay until sync rx=1 (break condition), then go IDLE.
- Push timing: the push occurs on sample 9 of the stop bit, so the next frame's start edge is detectable during the second half of the stop bit.
- FIFO behaviour:
  - Depth 2^FIFO_ADDR_WIDTH, circular pointers that wrap modulo depth.
  - FWFT: rx_data shows the head combinationally from registered storage. After a push into an empty FIFO, rx_valid is 1 on the next cycle.
  - Push and pop in the same cycle: count unchanged. This is legal even when full (no overrun) and when count=1.
  - Pop while empty is ignored.
- Error flags:
  - clear_errors clears both flags on the next edge.
  - If a set event and clear_errors coincide, set wins.
- Reset mid-frame: the FSM returns to IDLE, the FIFO empties and the partial byte is discarded. A line still held low after reset is treated as a start edge.

Test Plan:
- Single frame 0xA5 at 115200 (864 clk/bit), rx_ready=0 -> rx_valid=1 about 9.5 bit times after the start edge; rx_data=0xA5, rx_count=1, no flags set.
- 9 back-to-back frames 0x00..0x08 with rx_ready=0 -> rx_count=8; overrun=1 after the 9th frame; popping returns 0x00..0x07 in order.
- Frame 0x3C with stop bit forced low, line held low 3 bit times, then frame 0x42 -> frame_error=1, only 0x42 stored; clear_errors -> frame_error=0.
- Line glitch low for 300 clk, then high -> false start: no push, FSM returns to IDLE, the next valid frame 0x55 is received correctly.
- FIFO full (8 bytes), rx_ready=1 asserted in the stop-bit push cycle of frame 0x99 -> no overrun, rx_count stays 8, 0x99 is popped last.
- Assert rst during data bit 4 of frame 0xFF -> rx_valid=0, rx_count=0; the following frame 0x12 is received correctly.
